// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared types and constants for the time-multiplexed
// four-operand adder (state encoding, operand count, counter/sum widths).
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int unsigned NUM_OPS = 4;
  localparam int unsigned CNT_W   = $clog2(NUM_OPS);

  // Sum width that holds NUM_OPS * (2^data_w - 1) without wrapping.
  function automatic int unsigned sum_w(input int unsigned data_w);
    return data_w + CNT_W;
  endfunction

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. Searches from ptr upward,
// wrapping, and grants the first asserted request. The pointer register
// is owned by the caller.
// Ports:
//   req     in  N      request vector
//   ptr     in  IDX_W  index where the search starts
//   en      in  1      grant enable; no grant when low
//   gnt     out N      one-hot grant (zero when none)
//   gnt_idx out IDX_W  encoded grant index
//   any     out 1      a grant was issued
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // First requester at or after ptr, modulo N.
  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(ptr) + k) % N);
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// adder_sched: one shared accumulate adder serving NUM_REQ requesters.
// A granted request's four operands are summed over four cycles and the
// result is returned on a single response channel tagged with the ID.
// Optional macro ADDER_SCHED_PERF_EN adds the perf_busy_cnt port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready per-requester handshake (ready is one-hot or zero)
//   req_data        NUM_OPS operands of DATA_W bits per requester
//   rsp_valid/ready response handshake
//   rsp_sum, rsp_id result and served requester index
//   perf_busy_cnt   non-IDLE cycle count (ADDER_SCHED_PERF_EN only)
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*NUM_OPS*DATA_W-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W+1:0]             rsp_sum,
  output logic [ID_W-1:0]               rsp_id
`ifdef ADDER_SCHED_PERF_EN
  ,
  output logic [31:0]                   perf_busy_cnt
`endif
);

  localparam int unsigned ACC_W = sum_w(DATA_W);

  sched_state_t                         r_state;
  logic [ID_W-1:0]                      r_ptr;
  logic [ID_W-1:0]                      r_rsp_id;
  logic [CNT_W-1:0]                     r_cnt;
  logic [ACC_W-1:0]                     r_acc;
  logic [NUM_OPS-1:0][DATA_W-1:0]       r_ops;
  logic                                 r_rsp_valid;

  logic [NUM_REQ-1:0][NUM_OPS-1:0][DATA_W-1:0] w_req_ops;
  logic [NUM_REQ-1:0]                   w_gnt;
  logic [ID_W-1:0]                      w_gnt_idx;
  logic                                 w_any;
  logic                                 w_arb_en;

  // Packed view matches the flat layout: operand k of requester i at (i*NUM_OPS+k)*DATA_W.
  assign w_req_ops = req_data;

  // Accepts only in IDLE and never during the reset cycle.
  assign w_arb_en = (r_state == IDLE) && !rst;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_acc;
  assign rsp_id    = r_rsp_id;

  // Scheduler FSM: accept, accumulate one operand per cycle, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ops       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ops    <= w_req_ops[w_gnt_idx];
            r_rsp_id <= w_gnt_idx;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ptr    <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
            r_state  <= ACC;
          end
        end
        ACC: begin
          r_acc <= r_acc + ACC_W'(r_ops[r_cnt]);
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NUM_OPS - 1)) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDER_SCHED_PERF_EN
  logic [31:0] r_busy_cnt;

  // Free-running busy counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else if (r_state != IDLE) begin
      r_busy_cnt <= r_busy_cnt + 32'd1;
    end
  end

  assign perf_busy_cnt = r_busy_cnt;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: self-checking bench for adder_sched. A transaction-level
// reference (arbitration by search from a pointer, plain integer sums,
// accept/response timing arithmetic) predicts every observed output.
module tb_adder_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
  localparam int SUM_W   = DATA_W + 2;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*4*DATA_W-1:0]   req_data;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [SUM_W-1:0]              rsp_sum;
  logic [ID_W-1:0]               rsp_id;
`ifdef ADDER_SCHED_PERF_EN
  logic [31:0]                   perf_busy_cnt;
`endif

  adder_sched #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADDER_SCHED_PERF_EN
    ,
    .perf_busy_cnt (perf_busy_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          m_ptr;
  int unsigned ops [NUM_REQ][4];
  int          acc_log[$];
  int          acc_cyc[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_ops();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 4; k++)
        req_data[(i*4+k)*DATA_W +: DATA_W] = DATA_W'(ops[i][k]);
  endtask

  task automatic rand_ops(input int i);
    for (int k = 0; k < 4; k++) ops[i][k] = $urandom_range(0, 255);
  endtask

  function automatic int ref_grant(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int ref_sum(input int i);
    return int'(ops[i][0] + ops[i][1] + ops[i][2] + ops[i][3]);
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rand_ops(i);
    pack_ops();
    tick(); tick();
    req_valid = '1;
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== '0) begin errors++; $display("FAIL reset_rsp_sum: got %0d expected 0", rsp_sum); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
`ifdef ADDER_SCHED_PERF_EN
    checks++; if (perf_busy_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", perf_busy_cnt); end
`endif
    tick();
    rst = 1'b0; req_valid = '0;
    m_ptr = 0;
    // An accept during reset would surface as a response here.
    repeat (4) tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got rsp_valid %b expected 0", rsp_valid); end
    tick();
  endtask

  task automatic test_single();
    int g;
`ifdef ADDER_SCHED_PERF_EN
    logic [31:0] p0;
`endif
    ops[0][0] = 10; ops[0][1] = 20; ops[0][2] = 30; ops[0][3] = 40;
    pack_ops();
    req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk);
    g = ref_grant(req_valid, m_ptr);
    checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL single_grant: got %b expected %b", req_ready, onehot(g)); end
`ifdef ADDER_SCHED_PERF_EN
    p0 = perf_busy_cnt;
`endif
    tick();
    m_ptr = (g + 1) % NUM_REQ;
    req_valid = '1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL single_acc_ready c%0d: got %b expected 0", c, req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_acc_valid c%0d: got %b expected 0", c, rsp_valid); end
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_sum !== SUM_W'(100)) begin errors++; $display("FAIL single_sum: got %0d expected 100", rsp_sum); end
    checks++; if (rsp_id !== ID_W'(g)) begin errors++; $display("FAIL single_id: got %0d expected %0d", rsp_id, g); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
`ifdef ADDER_SCHED_PERF_EN
    checks++; if (perf_busy_cnt - p0 !== 32'd5) begin errors++; $display("FAIL single_perf: got %0d expected 5", perf_busy_cnt - p0); end
`endif
    tick();
  endtask

  task automatic test_max();
    int g;
    for (int k = 0; k < 4; k++) ops[2][k] = 255;
    pack_ops();
    req_valid = 4'b0100; rsp_ready = 1'b1;
    @(negedge clk);
    g = ref_grant(req_valid, m_ptr);
    checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL max_grant: got %b expected %b", req_ready, onehot(g)); end
    tick();
    m_ptr = (g + 1) % NUM_REQ;
    req_valid = '0;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_sum !== SUM_W'(ref_sum(2))) begin errors++; $display("FAIL max_sum: got %0d expected %0d", rsp_sum, ref_sum(2)); end
    checks++; if (rsp_id !== ID_W'(2)) begin errors++; $display("FAIL max_id: got %0d expected 2", rsp_id); end
    tick();
  endtask

  task automatic test_backpressure();
    int g;
    int g2;
    int exp_sum;
    rand_ops(1); pack_ops();
    req_valid = 4'b0010; rsp_ready = 1'b0;
    @(negedge clk);
    g = ref_grant(req_valid, m_ptr);
    checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL bp_grant: got %b expected %b", req_ready, onehot(g)); end
    exp_sum = ref_sum(1);
    tick();
    m_ptr = (g + 1) % NUM_REQ;
    req_valid = '0;
    repeat (4) tick();
    req_valid = '1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid h%0d: got %b expected 1", h, rsp_valid); end
      checks++; if (rsp_sum !== SUM_W'(exp_sum)) begin errors++; $display("FAIL bp_hold_sum h%0d: got %0d expected %0d", h, rsp_sum, exp_sum); end
      checks++; if (rsp_id !== ID_W'(1)) begin errors++; $display("FAIL bp_hold_id h%0d: got %0d expected 1", h, rsp_id); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_hold_ready h%0d: got %b expected 0", h, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b expected 1", rsp_valid); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_release_ready: got %b expected 0", req_ready); end
    tick();
    @(negedge clk);
    g2 = ref_grant(req_valid, m_ptr);
    checks++; if (req_ready !== onehot(g2)) begin errors++; $display("FAIL bp_next_accept: got %b expected %b", req_ready, onehot(g2)); end
    exp_sum = ref_sum(g2);
    tick();
    m_ptr = (g2 + 1) % NUM_REQ;
    req_valid = '0;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (rsp_sum !== SUM_W'(exp_sum) || rsp_id !== ID_W'(g2) || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_next_rsp: got v%b id%0d sum%0d expected v1 id%0d sum%0d", rsp_valid, rsp_id, rsp_sum, g2, exp_sum);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int exp_sum;
    rand_ops(0); pack_ops();
    req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    rand_ops(3); pack_ops();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== onehot(ref_grant(req_valid, m_ptr))) begin errors++; $display("FAIL abort_regrant: got %b expected %b", req_ready, onehot(ref_grant(req_valid, m_ptr))); end
`ifdef ADDER_SCHED_PERF_EN
    checks++; if (perf_busy_cnt !== 32'd0) begin errors++; $display("FAIL abort_perf_clear: got %0d expected 0", perf_busy_cnt); end
`endif
    exp_sum = ref_sum(3);
    tick();
    m_ptr = 0;
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_stale c%0d: got %b expected 0", c, rsp_valid); end
      tick();
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== SUM_W'(exp_sum) || rsp_id !== ID_W'(3)) begin
      errors++; $display("FAIL abort_rsp: got v%b id%0d sum%0d expected v1 id3 sum%0d", rsp_valid, rsp_id, rsp_sum, exp_sum);
    end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_drop: got %b expected 0", rsp_valid); end
`ifdef ADDER_SCHED_PERF_EN
    checks++; if (perf_busy_cnt !== 32'd5) begin errors++; $display("FAIL abort_perf: got %0d expected 5", perf_busy_cnt); end
`endif
    tick();
  endtask

  // Cycle loop against the transaction-level model; rnd selects random
  // valid/ready traffic, otherwise all requesters valid and rsp_ready high.
  task automatic test_traffic(input bit rnd, input int ncyc);
    bit pend;
    int idle_at, rsp_at, exp_sum, exp_id, g;
    bit ev;
    logic [NUM_REQ-1:0] exp_rdy;
    pend = 0; idle_at = 0; rsp_at = 0; exp_sum = 0; exp_id = 0;
    acc_log.delete(); acc_cyc.delete();
    for (int cyc = 0; cyc < ncyc + 12; cyc++) begin
      if (cyc >= ncyc) begin
        req_valid = '0; rsp_ready = 1'b1;
      end else if (rnd) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i]) begin
            if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
          end else begin
            req_valid[i] = ($urandom_range(0, 2) == 0);
          end
        end
        rsp_ready = ($urandom_range(0, 1) == 1);
      end else begin
        req_valid = '1; rsp_ready = 1'b1;
      end
      pack_ops();
      @(negedge clk);
      g = (!pend && cyc >= idle_at) ? ref_grant(req_valid, m_ptr) : -1;
      exp_rdy = onehot(g);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL traffic_ready cyc%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
      ev = pend && (cyc >= rsp_at);
      checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL traffic_valid cyc%0d: got %b expected %b", cyc, rsp_valid, ev); end
      if (ev) begin
        checks++; if (rsp_sum !== SUM_W'(exp_sum) || rsp_id !== ID_W'(exp_id)) begin
          errors++; $display("FAIL traffic_rsp cyc%0d: got id%0d sum%0d expected id%0d sum%0d", cyc, rsp_id, rsp_sum, exp_id, exp_sum);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] === 1'b1) begin acc_log.push_back(i); acc_cyc.push_back(cyc); end
      end
      if (g >= 0) begin
        pend = 1; rsp_at = cyc + 5;
        exp_sum = ref_sum(g); exp_id = g;
        m_ptr = (g + 1) % NUM_REQ;
        rand_ops(g);
      end else if (ev && rsp_ready) begin
        pend = 0; idle_at = cyc + 1;
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0; m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) rand_ops(i);
    test_traffic(1'b0, 30);
    checks++;
    if (acc_log.size() < 5) begin
      errors++; $display("FAIL rr_count: got %0d accepts expected at least 5", acc_log.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++; if (acc_log[j] != exp_order[j]) begin errors++; $display("FAIL rr_order %0d: got %0d expected %0d", j, acc_log[j], exp_order[j]); end
      end
      for (int j = 1; j < 5; j++) begin
        checks++; if (acc_cyc[j] - acc_cyc[j-1] != 6) begin errors++; $display("FAIL rr_spacing %0d: got %0d expected 6", j, acc_cyc[j] - acc_cyc[j-1]); end
      end
    end
  endtask

  task automatic test_random();
    req_valid = '0;
    test_traffic(1'b1, 600);
  endtask

  initial begin
    checks = 0; errors = 0; m_ptr = 0;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_data = '0;
    test_reset();
    test_single();
    test_max();
    test_backpressure();
    test_reset_abort();
    test_round_robin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_sched.md
# adder_sched

Time-multiplexed four-operand adder shared among `NUM_REQ` requesters. Each requester submits four unsigned `DATA_W`-bit operands through a valid/ready handshake. A round-robin arbiter grants one request at a time, and a single `DATA_W+2`-bit accumulate adder sums the four operands over four cycles. The result goes out on one response channel tagged with the requester ID. It sits between the datapath clients and the shared arithmetic resource, replacing per-client adder trees.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_W`, 8: operand width.
- `ID_W`, `$clog2(NUM_REQ)`: width of the response ID.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; one-hot or zero.
- `req_data`  in  `NUM_REQ*4*DATA_W`  four operands per requester; operand k of requester i at bits `[(i*4+k)*DATA_W +: DATA_W]`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  `DATA_W+2`  sum of the four operands.
- `rsp_id`  out  `ID_W`  index of the requester served.
- `perf_busy_cnt`  out  32  non-IDLE cycle count; present only with `ADDER_SCHED_PERF_EN`.

## Operation
- FSM states: IDLE, ACC, RESP.
- **IDLE**
  - `req_ready` is the combinational round-robin grant of `req_valid`, gated by `state==IDLE`.
  - On a handshake: latch the four operands of the granted requester, latch `rsp_id`, clear the accumulator, set `cnt=0`, move to ACC.
  - The round-robin pointer moves to grant+1 mod `NUM_REQ`.
- **ACC**
  - Each cycle: `acc <= acc + zext(op[cnt])`, `cnt++`.
  - After the `cnt==3` cycle, move to RESP.
  - `req_ready` stays 0.
- **RESP**
  - `rsp_valid=1`, `rsp_sum=acc`, `rsp_id` held stable.
  - When `rsp_ready` is high, return to IDLE.
  - `rsp_sum` and `rsp_id` must not change while `rsp_valid && !rsp_ready`.
- **Arithmetic**
  - Operands are zero-extended to `DATA_W+2` bits.
  - The maximum result 4·(2^DATA_W−1) fits, so there is no overflow and no wrap.
- **Arbitration**
  - Search starts at the pointer and takes the lowest index ≥ pointer, wrapping around.
  - A requester that drops `req_valid` before grant is simply skipped.
  - No fairness credit is kept for requests not granted.
- A request held valid while not granted must stay valid with stable data (requester obligation). The block does not check this.

## Timing
- Reset values:
  - state IDLE, pointer 0, `cnt` 0, `acc` 0.
  - `req_ready` 0 during the reset cycle.
  - `rsp_valid` 0, `rsp_sum` 0, `rsp_id` 0.
  - `perf_busy_cnt` 0.
- Latency: handshake in cycle T, ACC in T+1..T+4, `rsp_valid` first high in T+5.
- Minimum request-to-request spacing is 6 cycles. The RESP→IDLE transition costs one cycle; no accept happens in the same cycle as the response handshake.
- Reset asserted in any state:
  - The next cycle is IDLE with `rsp_valid=0`.
  - In-flight operands are discarded and the pointer returns to 0.
  - No response is emitted for the aborted request.
- Reset and `req_valid` high in the same cycle: no accept.

## Configuration
- `ADDER_SCHED_PERF_EN` defined:
  - `perf_busy_cnt` port exists and increments every cycle the state is not IDLE.
  - It wraps at 2^32 and clears on `rst`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `adder_sched_pkg`:
  - state enum `sched_state_t {IDLE, ACC, RESP}`.
  - constant `NUM_OPS=4`.
  - localparam helper for `cnt` width (2).
- Sub-module `rr_arbiter`:
  - parameter `N`.
  - inputs: `req`, `ptr`, `en`.
  - outputs: one-hot `gnt`, encoded `gnt_idx`, `any`.
  - purely combinational; the pointer register lives in the top level.

## Test plan
- Single request, requester 0, operands 10,20,30,40, `rsp_ready` tied high: `req_ready[0]` high at T, `rsp_valid` at T+5 with `rsp_sum=100`, `rsp_id=0`, low at T+6.
- Maximum operands on requester 2, all 255: `rsp_sum=1020`, `rsp_id=2`, no truncation.
- All four requesters valid continuously with distinct data: grant order 0,1,2,3,0, each response carrying the correct ID and sum, accepts spaced 6 cycles apart.
- Backpressure: `rsp_ready` low for 3 cycles after `rsp_valid` rises: `rsp_sum` and `rsp_id` stable, `req_ready` all 0, response accepted on the 4th cycle, next accept one cycle later.
- `rst` pulsed in the second ACC cycle: next cycle `rsp_valid=0`, state IDLE; the following request from requester 3 is granted with correct sum and no stale response appears.
- With `ADDER_SCHED_PERF_EN`: after one uncontended transaction with immediate `rsp_ready`, `perf_busy_cnt=5`. Without the macro, the build compiles with the port absent.
